// File: rtl/alu_iter_pkg.sv
// Shared opcode, flag and width definitions for the iterative ALU.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_iter_if.sv
// Operand/opcode/result bundle between the control sequencer and the ALU.
interface alu_iter_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic [WIDTH-1:0]    i_a;
  logic [WIDTH-1:0]    i_b;
  logic                i_bWr;
  logic                i_start;
  logic [ALU_OP_W-1:0] i_aluOp;
  logic                o_busy;
  logic                o_done;
  logic [WIDTH-1:0]    o_y;
  logic [WIDTH-1:0]    o_yHi;
  logic                o_negative;
  logic                o_zero;
  logic                o_carry;
  logic                o_overflow;

  modport master (
    output i_a, i_b, i_bWr, i_start, i_aluOp,
    input  o_busy, o_done, o_y, o_yHi, o_negative, o_zero, o_carry, o_overflow
  );

  modport slave (
    input  i_a, i_b, i_bWr, i_start, i_aluOp,
    output o_busy, o_done, o_y, o_yHi, o_negative, o_zero, o_carry, o_overflow
  );

endinterface

// File: rtl/alu_iter_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_nReset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] step_s;
  logic               done_s;

  // acc holds {partial high, remaining multiplier}; each step adds and shifts right
  always_comb begin
    sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_s  = {sum_s, acc_q[WIDTH-1:1]};
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = {SHAMT_W{1'b0}};
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = step_s;
        cnt_d = cnt_q + {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiplier state registers
  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {SHAMT_W{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  // product is the value the final step produces, consumed on the done edge
  assign busy    = (state_q == ST_RUN);
  assign done    = done_s;
  assign product = step_s;

endmodule

// File: rtl/alu_iter.sv
// WIDTH-bit ALU: single-cycle logic/arith/shift ops plus an iterative multiply,
// with latched B operand and registered result/flags.
module alu_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       i_clk,
  input  logic       i_nReset,
  alu_iter_if.slave  bus
);

  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   y_hi_q, y_hi_d;
  alu_flags_t         flags_q, flags_d;
  logic               done_q, done_d;

  alu_op_e            op_s;
  logic               accept_s;
  logic               mul_start_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;
  logic [SHAMT_W-1:0] amt_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     shr_s;
  logic [WIDTH-1:0]   res_s;
  logic               res_c_s;
  logic               res_v_s;
  alu_flags_t         res_flags_s;
  alu_flags_t         mul_flags_s;

  assign op_s        = alu_op_e'(bus.i_aluOp);
  assign accept_s    = bus.i_start && !mul_busy_s;
  assign mul_start_s = accept_s && (op_s == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk    (i_clk),
    .i_nReset (i_nReset),
    .start    (mul_start_s),
    .a        (bus.i_a),
    .b        (b_q),
    .busy     (mul_busy_s),
    .done     (mul_done_s),
    .product  (mul_product_s)
  );

  // Single-cycle datapath; shifters carry an extra bit to catch the last bit out
  always_comb begin
    amt_s = b_q[SHAMT_W-1:0];
    add_s = {1'b0, bus.i_a} + {1'b0, b_q};
    sub_s = {1'b0, bus.i_a} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    shl_s = {1'b0, bus.i_a};
    shr_s = {bus.i_a, 1'b0};
    for (int k = 0; k < SHAMT_W; k++) begin
      if (amt_s[k]) begin
        shl_s = shl_s << (2 ** k);
        shr_s = shr_s >> (2 ** k);
      end else begin
        shl_s = shl_s;
        shr_s = shr_s;
      end
    end
    res_s   = {WIDTH{1'b0}};
    res_c_s = 1'b0;
    res_v_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        res_s   = add_s[WIDTH-1:0];
        res_c_s = add_s[WIDTH];
        res_v_s = (bus.i_a[WIDTH-1] == b_q[WIDTH-1]) && (res_s[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = sub_s[WIDTH-1:0];
        res_c_s = sub_s[WIDTH];
        res_v_s = (bus.i_a[WIDTH-1] != b_q[WIDTH-1]) && (res_s[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      OP_AND: res_s = bus.i_a & b_q;
      OP_XOR: res_s = bus.i_a ^ b_q;
      OP_OR:  res_s = bus.i_a | b_q;
      OP_SHL: begin
        res_s   = shl_s[WIDTH-1:0];
        res_c_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_s   = shr_s[WIDTH:1];
        res_c_s = shr_s[0];
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
    res_flags_s.n = res_s[WIDTH-1];
    res_flags_s.z = (res_s == {WIDTH{1'b0}});
    res_flags_s.c = res_c_s;
    res_flags_s.v = res_v_s;
    mul_flags_s.n = mul_product_s[WIDTH-1];
    mul_flags_s.z = (mul_product_s == {(2*WIDTH){1'b0}});
    mul_flags_s.c = (mul_product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    mul_flags_s.v = 1'b0;
  end

  // Next values: B load when idle, result/flags only on a completion
  always_comb begin
    if (bus.i_bWr && !mul_busy_s) begin
      b_d = bus.i_b;
    end else begin
      b_d = b_q;
    end
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (mul_done_s) begin
      y_d     = mul_product_s[WIDTH-1:0];
      y_hi_d  = mul_product_s[2*WIDTH-1:WIDTH];
      flags_d = mul_flags_s;
      done_d  = 1'b1;
    end else if (accept_s && (op_s != OP_MUL)) begin
      y_d     = res_s;
      y_hi_d  = {WIDTH{1'b0}};
      flags_d = res_flags_s;
      done_d  = 1'b1;
    end else begin
      done_d  = 1'b0;
    end
  end

  // Architectural registers
  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      b_q     <= {WIDTH{1'b0}};
      y_q     <= {WIDTH{1'b0}};
      y_hi_q  <= {WIDTH{1'b0}};
      flags_q <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
      done_q  <= 1'b0;
    end else begin
      b_q     <= b_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy     = mul_busy_s;
  assign bus.o_done     = done_q;
  assign bus.o_y        = y_q;
  assign bus.o_yHi      = y_hi_q;
  assign bus.o_negative = flags_q.n;
  assign bus.o_zero     = flags_q.z;
  assign bus.o_carry    = flags_q.c;
  assign bus.o_overflow = flags_q.v;

endmodule

// File: tb/tb_alu_iter.sv
// Directed plus randomized check of alu_iter (WIDTH=8) against an arithmetic model.
module tb_alu_iter;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mb = 0;

  alu_iter_if #(.WIDTH(8)) bus ();

  alu_iter #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_nReset (n_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, bus.o_negative, bus.o_zero, bus.o_carry, bus.o_overflow};
  endfunction

  // Behavioural reference: plain integer arithmetic, flags as {n,z,c,v}
  function automatic void model(input int op, input int a, input int b,
                                output int y, output int yh, output logic [3:0] f);
    int sa, sb, sr, amt, p;
    logic c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    amt = b % 8;
    c = 1'b0; v = 1'b0; y = 0; yh = 0;
    case (op)
      0: begin y = (a + b) % 256; c = ((a + b) > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      1: begin y = (a - b + 256) % 256; c = (a >= b); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      2: y = a & b;
      3: y = a ^ b;
      4: y = a | b;
      5: begin y = (a << amt) % 256; c = (amt != 0) && (((a >> (8 - amt)) & 1) == 1); end
      6: begin y = a >> amt; c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1); end
      default: begin p = a * b; y = p % 256; yh = p / 256; c = (yh != 0); end
    endcase
    f = {(y >= 128), ((op == 7) ? (y == 0 && yh == 0) : (y == 0)), c, v};
  endfunction

  task automatic write_b(input int v);
    bus.i_bWr = 1'b1;
    bus.i_b   = v[7:0];
    tick();
    bus.i_bWr = 1'b0;
    mb = v;
  endtask

  task automatic issue(input int op, input int a, input bit wr, input int bv, input string tag);
    int ey, eyh, waited;
    logic [3:0] ef;
    model(op, a, mb, ey, eyh, ef);
    bus.i_start = 1'b1;
    bus.i_aluOp = op[2:0];
    bus.i_a     = a[7:0];
    bus.i_bWr   = wr;
    bus.i_b     = bv[7:0];
    tick();
    if (wr) mb = bv;
    bus.i_start = 1'b0;
    bus.i_bWr   = 1'b0;
    if (op == 7) begin
      waited = 0;
      while (bus.o_busy === 1'b1 && waited < 20) begin
        waited++;
        tick();
      end
      chk({tag, "_busy_cycles"}, waited, 8);
    end
    chk({tag, "_done"}, 32'(bus.o_done), 1);
    chk({tag, "_y"}, 32'(bus.o_y), ey);
    chk({tag, "_yhi"}, 32'(bus.o_yHi), eyh);
    chk({tag, "_flags"}, flags_now(), 32'(ef));
  endtask

  initial begin
    int waited, dones, op, a, bv;
    logic [7:0] y_hold;
    bus.i_a = 8'h00; bus.i_b = 8'h00; bus.i_bWr = 1'b0;
    bus.i_start = 1'b0; bus.i_aluOp = 3'b000;

    // Reset state
    tick(); tick();
    chk("rst_y", 32'(bus.o_y), 0);
    chk("rst_yhi", 32'(bus.o_yHi), 0);
    chk("rst_flags", flags_now(), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    n_reset = 1'b1;
    tick();

    // Directed single-cycle cases
    write_b(8'h01);
    issue(0, 8'h7F, 1'b0, 0, "add_ovf");
    y_hold = bus.o_y;
    tick();
    chk("add_done_one_cycle", 32'(bus.o_done), 0);
    chk("add_hold_y", 32'(bus.o_y), 32'(y_hold));
    write_b(8'h05);
    issue(1, 8'h05, 1'b0, 0, "sub_zero");
    write_b(8'h01);
    issue(1, 8'h80, 1'b0, 0, "sub_ovf");
    write_b(8'h09);
    issue(5, 8'h81, 1'b0, 0, "shl_amt1");
    write_b(8'h00);
    issue(6, 8'h5A, 1'b0, 0, "shr_amt0");

    // MUL with start and B write attempted while busy
    write_b(8'hFF);
    bus.i_start = 1'b1; bus.i_aluOp = 3'b111; bus.i_a = 8'hFF;
    tick();
    bus.i_start = 1'b0;
    waited = 0; dones = 0;
    while (bus.o_busy === 1'b1 && waited < 20) begin
      waited++;
      if (bus.o_done === 1'b1) dones++;
      if (waited == 3) begin
        bus.i_start = 1'b1; bus.i_aluOp = 3'b010; bus.i_bWr = 1'b1; bus.i_b = 8'h00;
      end
      tick();
      bus.i_start = 1'b0; bus.i_bWr = 1'b0;
    end
    chk("mul_busy_cycles", waited, 8);
    chk("mul_no_early_done", dones, 0);
    chk("mul_done", 32'(bus.o_done), 1);
    chk("mul_y", 32'(bus.o_y), 32'h01);
    chk("mul_yhi", 32'(bus.o_yHi), 32'hFE);
    chk("mul_flags", flags_now(), 32'h2);
    tick();
    chk("mul_single_done", 32'(bus.o_done), 0);
    issue(2, 8'hAB, 1'b0, 0, "b_kept_after_busy");

    // Reset in the middle of a MUL
    write_b(8'h23);
    bus.i_start = 1'b1; bus.i_aluOp = 3'b111; bus.i_a = 8'h45;
    tick();
    bus.i_start = 1'b0;
    tick(); tick();
    n_reset = 1'b0;
    tick();
    chk("abort_y", 32'(bus.o_y), 0);
    chk("abort_yhi", 32'(bus.o_yHi), 0);
    chk("abort_flags", flags_now(), 0);
    chk("abort_busy", 32'(bus.o_busy), 0);
    chk("abort_done", 32'(bus.o_done), 0);
    n_reset = 1'b1;
    mb = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    issue(0, 8'h33, 1'b0, 0, "b_reset_zero");

    // Back-to-back: XOR in the MUL done cycle, then same-edge B write plus start
    write_b(8'h37);
    issue(7, 8'h9C, 1'b0, 0, "b2b_mul");
    issue(3, 8'hC5, 1'b0, 0, "b2b_xor");
    issue(0, 8'h10, 1'b1, 8'h60, "same_edge_old_b");
    issue(4, 8'h01, 1'b0, 0, "same_edge_new_b");

    // Randomized operations, optionally back-to-back and with same-edge B writes
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      issue(op, a, 1'($urandom_range(0, 1)), bv, "rand");
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand_idle_done", 32'(bus.o_done), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
